// File: rtl/axi_io_reg_slave_if.sv
// AXI4 bus bundle between the role's 32-bit IO master and the register-array responder.
interface axi_io_reg_slave_if;
  logic [31:0] awaddr;
  logic [1:0]  awburst;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [1:0]  arburst;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awburst, awlen, awsize, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    output araddr, arburst, arlen, arsize, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awaddr, awburst, awlen, awsize, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    input  araddr, arburst, arlen, arsize, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_io_reg_slave.sv
// AXI4 responder terminating IO-master bursts into a local 32-bit register array.
// Define AXI_IO_SLV_WRAP_BURST_EN to accept WRAP bursts; otherwise every WRAP beat is SLVERR.
module axi_io_reg_slave #(
  parameter int unsigned NUM_REGS  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic               aclk,
  input logic               areset,
  axi_io_reg_slave_if.slave bus
);

`ifdef AXI_IO_SLV_WRAP_BURST_EN
  localparam logic WrapEn = 1'b1;
`else
  localparam logic WrapEn = 1'b0;
`endif

  localparam int unsigned IdxW      = $clog2(NUM_REGS);
  localparam logic [31:0] SpanBytes = 32'(NUM_REGS * 4);

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  function automatic logic beat_ok(logic [31:0] addr, logic [7:0] len, logic [1:0] burst,
                                   logic [2:0] size);
    logic ok;
    logic len_legal;
    len_legal = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    ok = (size == 3'b010) && ((addr - BASE_ADDR) < SpanBytes) && (burst != 2'b11);
    if (burst == 2'b10 && !(WrapEn && len_legal)) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [31:0] next_addr(logic [31:0] addr, logic [7:0] len,
                                            logic [1:0] burst);
    logic [31:0] mask;
    logic [31:0] res;
    mask = (({24'd0, len} + 32'd1) << 2) - 32'd1;
    case (burst)
      2'b01:   res = addr + 32'd4;
      2'b10:   res = (addr & ~mask) | ((addr + 32'd4) & mask);
      default: res = addr;
    endcase
    return res;
  endfunction

  logic [31:0] regs [NUM_REGS];

  // Write channel state
  w_state_e    w_state;
  logic [31:0] w_addr;
  logic [7:0]  w_len;
  logic [7:0]  w_beat;
  logic [1:0]  w_burst;
  logic [2:0]  w_size;
  logic        w_err;
  logic        w_ok;
  logic        w_err_nxt;
  logic [IdxW-1:0] w_idx;

  assign w_ok      = beat_ok(w_addr, w_len, w_burst, w_size);
  assign w_idx     = IdxW'((w_addr - BASE_ADDR) >> 2);
  assign w_err_nxt = w_err | ~w_ok | (bus.wlast != (w_beat == w_len));

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state     <= WIdle;
      bus.awready <= 1'b1;
      bus.wready  <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bresp   <= 2'b00;
      w_addr      <= '0;
      w_len       <= '0;
      w_beat      <= '0;
      w_burst     <= '0;
      w_size      <= '0;
      w_err       <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      unique case (w_state)
        WIdle: begin
          if (bus.awvalid) begin
            w_addr      <= bus.awaddr;
            w_len       <= bus.awlen;
            w_burst     <= bus.awburst;
            w_size      <= bus.awsize;
            w_beat      <= '0;
            w_err       <= 1'b0;
            bus.awready <= 1'b0;
            bus.wready  <= 1'b1;
            w_state     <= WData;
          end
        end
        WData: begin
          if (bus.wvalid) begin
            if (w_ok) begin
              for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) regs[w_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
              end
            end
            w_err <= w_err_nxt;
            // A missing wlast still closes the burst after len+1 beats.
            if (bus.wlast || (w_beat == w_len)) begin
              bus.wready <= 1'b0;
              bus.bvalid <= 1'b1;
              bus.bresp  <= w_err_nxt ? 2'b10 : 2'b00;
              w_state    <= WResp;
            end else begin
              w_beat <= w_beat + 8'd1;
              w_addr <= next_addr(w_addr, w_len, w_burst);
            end
          end
        end
        WResp: begin
          if (bus.bready) begin
            bus.bvalid  <= 1'b0;
            bus.awready <= 1'b1;
            w_state     <= WIdle;
          end
        end
        default: w_state <= WIdle;
      endcase
    end
  end

  // Read channel state
  r_state_e    r_state;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_beat;
  logic [1:0]  r_burst;
  logic [2:0]  r_size;
  logic [31:0] r_nxt_addr;
  logic [31:0] ld_addr;
  logic        ld_ok;
  logic [IdxW-1:0] ld_idx;

  assign r_nxt_addr = next_addr(r_addr, r_len, r_burst);

  // Address of the beat loaded at the next edge: AR address when idle, else the stepped one.
  always_comb begin
    ld_addr = r_nxt_addr;
    ld_ok   = beat_ok(r_nxt_addr, r_len, r_burst, r_size);
    if (r_state == RIdle) begin
      ld_addr = bus.araddr;
      ld_ok   = beat_ok(bus.araddr, bus.arlen, bus.arburst, bus.arsize);
    end
  end

  assign ld_idx = IdxW'((ld_addr - BASE_ADDR) >> 2);

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state     <= RIdle;
      bus.arready <= 1'b1;
      bus.rvalid  <= 1'b0;
      bus.rlast   <= 1'b0;
      bus.rresp   <= 2'b00;
      bus.rdata   <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_burst     <= '0;
      r_size      <= '0;
    end else begin
      unique case (r_state)
        RIdle: begin
          if (bus.arvalid) begin
            r_addr      <= bus.araddr;
            r_len       <= bus.arlen;
            r_burst     <= bus.arburst;
            r_size      <= bus.arsize;
            r_beat      <= '0;
            bus.rdata   <= ld_ok ? regs[ld_idx] : 32'd0;
            bus.rresp   <= ld_ok ? 2'b00 : 2'b10;
            bus.rlast   <= (bus.arlen == 8'd0);
            bus.rvalid  <= 1'b1;
            bus.arready <= 1'b0;
            r_state     <= RData;
          end
        end
        RData: begin
          if (bus.rready) begin
            if (bus.rlast) begin
              bus.rvalid  <= 1'b0;
              bus.rlast   <= 1'b0;
              bus.arready <= 1'b1;
              r_state     <= RIdle;
            end else begin
              r_addr    <= r_nxt_addr;
              r_beat    <= r_beat + 8'd1;
              bus.rdata <= ld_ok ? regs[ld_idx] : 32'd0;
              bus.rresp <= ld_ok ? 2'b00 : 2'b10;
              bus.rlast <= ((r_beat + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= RIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_io_reg_slave.sv
// Directed bench for axi_io_reg_slave: bursts, strobes, range errors, stalls, WRAP and reset.
module tb_axi_io_reg_slave;
  localparam logic [31:0] Base = 32'h4000_0100;
  localparam logic [1:0]  Incr = 2'b01;
  localparam logic [1:0]  Wrap = 2'b10;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  axi_io_reg_slave_if bus ();

  axi_io_reg_slave #(
    .NUM_REGS (16),
    .BASE_ADDR(Base)
  ) dut (
    .aclk  (aclk),
    .areset(areset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] e [8];
  int beat;
  int cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int t = 0;
    bus.awaddr = addr; bus.awlen = len; bus.awburst = burst; bus.awsize = 3'b010;
    bus.awvalid = 1'b1;
    while (bus.awready !== 1'b1 && t < 20) begin @(negedge aclk); t++; end
    check("awready", bus.awready, 1);
    @(negedge aclk);
    bus.awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int t = 0;
    bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
    while (bus.wready !== 1'b1 && t < 20) begin @(negedge aclk); t++; end
    check("wready", bus.wready, 1);
    @(negedge aclk);
    bus.wvalid = 1'b0;
  endtask

  task automatic b_recv(input logic [1:0] resp);
    int t = 0;
    bus.bready = 1'b1;
    while (bus.bvalid !== 1'b1 && t < 20) begin @(negedge aclk); t++; end
    check("bvalid", bus.bvalid, 1);
    check("bresp", bus.bresp, resp);
    @(negedge aclk);
    bus.bready = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int t = 0;
    bus.araddr = addr; bus.arlen = len; bus.arburst = burst; bus.arsize = 3'b010;
    bus.arvalid = 1'b1;
    while (bus.arready !== 1'b1 && t < 20) begin @(negedge aclk); t++; end
    check("arready", bus.arready, 1);
    @(negedge aclk);
    bus.arvalid = 1'b0;
  endtask

  task automatic r_beat(input logic [31:0] data, input logic [1:0] resp, input logic last);
    int t = 0;
    bus.rready = 1'b1;
    while (bus.rvalid !== 1'b1 && t < 20) begin @(negedge aclk); t++; end
    check("rvalid", bus.rvalid, 1);
    check("rdata", bus.rdata, data);
    check("rresp", bus.rresp, resp);
    check("rlast", bus.rlast, last);
    @(negedge aclk);
    bus.rready = 1'b0;
  endtask

  task automatic wr1(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                     input logic [1:0] resp);
    aw_send(addr, 8'd0, Incr);
    w_send(data, strb, 1'b1);
    b_recv(resp);
  endtask

  task automatic rd1(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    ar_send(addr, 8'd0, Incr);
    r_beat(data, resp, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.awaddr = '0; bus.awburst = '0; bus.awlen = '0; bus.awsize = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arburst = '0; bus.arlen = '0; bus.arsize = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    check("rst_awready", bus.awready, 1);
    check("rst_arready", bus.arready, 1);
    check("rst_wready", bus.wready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_rlast", bus.rlast, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_resp", {bus.bresp, bus.rresp}, 0);
    areset = 1'b0;
    @(negedge aclk);

    // INCR write and read-back of regs 0..3
    aw_send(Base, 8'd3, Incr);
    for (int i = 0; i < 4; i++) w_send(32'(i + 1), 4'hF, i == 3);
    b_recv(2'b00);
    ar_send(Base, 8'd3, Incr);
    for (int i = 0; i < 4; i++) r_beat(32'(i + 1), 2'b00, i == 3);

    // Partial byte strobes
    wr1(Base + 32'h24, 32'hAABB_CCDD, 4'b0101, 2'b00);
    rd1(Base + 32'h24, 32'h00BB_00DD, 2'b00);

    // Read running off the top of the array
    wr1(Base + 32'h3C, 32'h1234_5678, 4'hF, 2'b00);
    ar_send(Base + 32'h3C, 8'd1, Incr);
    r_beat(32'h1234_5678, 2'b00, 1'b0);
    r_beat(32'h0, 2'b10, 1'b1);

    // Below-base write, then early wlast
    wr1(Base - 32'h4, 32'h99, 4'hF, 2'b10);
    aw_send(Base + 32'h28, 8'd1, Incr);
    w_send(32'h77, 4'hF, 1'b1);
    b_recv(2'b10);
    rd1(Base + 32'h28, 32'h77, 2'b00);

    aw_send(Base + 32'h10, 8'd3, Incr);
    w_send(32'h55, 4'hF, 1'b0);
    w_send(32'h66, 4'hF, 1'b0);
    w_send(32'h77, 4'hF, 1'b0);
    w_send(32'h88, 4'hF, 1'b1);
    b_recv(2'b00);
    e[0] = 32'h1; e[1] = 32'h2; e[2] = 32'h3; e[3] = 32'h4;
    e[4] = 32'h55; e[5] = 32'h66; e[6] = 32'h77; e[7] = 32'h88;

    // rready toggling: data must hold during stalls
    ar_send(Base, 8'd7, Incr);
    beat = 0;
    cyc  = 0;
    while (beat < 8 && cyc < 64) begin
      bus.rready = ~bus.rready;
      check("stall_rvalid", bus.rvalid, 1);
      check("stall_rdata", bus.rdata, e[beat]);
      check("stall_rlast", bus.rlast, 32'(beat == 7));
      if (bus.rready) beat++;
      @(negedge aclk);
      cyc++;
    end
    bus.rready = 1'b0;
    check("stall_beats", beat, 8);
    check("stall_done", bus.rvalid, 0);

    // rready tied high: eight back-to-back beats
    bus.rready = 1'b1;
    ar_send(Base, 8'd7, Incr);
    for (int i = 0; i < 8; i++) begin
      check("tput_rvalid", bus.rvalid, 1);
      check("tput_rdata", bus.rdata, e[i]);
      check("tput_rlast", bus.rlast, 32'(i == 7));
      @(negedge aclk);
    end
    check("tput_done", bus.rvalid, 0);
    bus.rready = 1'b0;

    ar_send(Base + 32'h8, 8'd3, Wrap);
`ifdef AXI_IO_SLV_WRAP_BURST_EN
    r_beat(32'h3, 2'b00, 1'b0);
    r_beat(32'h4, 2'b00, 1'b0);
    r_beat(32'h1, 2'b00, 1'b0);
    r_beat(32'h2, 2'b00, 1'b1);
`else
    for (int i = 0; i < 4; i++) r_beat(32'h0, 2'b10, i == 3);
`endif

    // Reset in the middle of a write burst
    aw_send(Base + 32'h30, 8'd3, Incr);
    w_send(32'hA, 4'hF, 1'b0);
    w_send(32'hB, 4'hF, 1'b0);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    check("mid_rst_awready", bus.awready, 1);
    check("mid_rst_wready", bus.wready, 0);
    @(negedge aclk);
    check("mid_rst_bvalid", bus.bvalid, 0);
    rd1(Base + 32'h30, 32'h0, 2'b00);
    rd1(Base, 32'h0, 2'b00);
    rd1(Base + 32'h3C, 32'h0, 2'b00);
    wr1(Base + 32'h30, 32'hCAFE_F00D, 4'hF, 2'b00);
    rd1(Base + 32'h30, 32'hCAFE_F00D, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
